block_engine_sequencer: RTL and testbench

Consumer end of the word-to-block assembler's block handshake. The sequencer pulls one BSIZE block at a time from the assembler and launches it on a block processing engine with a one-cycle start pulse. It waits for the engine's done signal and queues the result block in a small show-ahead buffer. The buffer feeds the block-to-word disassembler's block_in_ready/pull_block handshake. It sits between the two converters in the coprocessor datapath.

---
 rtl/block_transfer_pkg.sv | 14 +
 rtl/block_result_queue.sv | 74 +++++++
 rtl/block_engine_sequencer.sv | 142 ++++++++++++++
 tb/tb_block_engine_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_transfer_pkg.sv
// Shared definitions for the block engine sequencer and its result queue.
package block_transfer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2
  } seq_state_e;

  localparam int unsigned DefaultBsize   = 128;
  localparam int unsigned ProcCountWidth = 16;
  localparam int unsigned WdogCountWidth = 16;

endpackage

// File: rtl/block_result_queue.sv
// Show-ahead circular buffer holding engine results until the disassembler pulls them.
module block_result_queue
  import block_transfer_pkg::*;
#(
  parameter int unsigned Width = DefaultBsize,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic             full_o
);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("block_result_queue: Depth must be a power of two and at least 2");
  end

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Masked when empty so a flushed queue presents zero rather than stale data.
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/block_engine_sequencer.sv
// Pulls blocks from the assembler, runs them one at a time on the engine, queues results.
// Optional engine watchdog compiled in with ENGINE_WATCHDOG_EN.
module block_engine_sequencer
  import block_transfer_pkg::*;
#(
  parameter int unsigned BSIZE           = DefaultBsize,
  parameter int unsigned QDEPTH          = 4,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [BSIZE-1:0]          block_in,
  input  logic                      block_in_ready,
  output logic                      block_in_hold,
  output logic [BSIZE-1:0]          eng_block,
  output logic                      eng_start,
  input  logic [BSIZE-1:0]          eng_result,
  input  logic                      eng_done,
  output logic [BSIZE-1:0]          block_out,
  output logic                      block_out_ready,
  input  logic                      pull_block,
  output logic [ProcCountWidth-1:0] blocks_processed,
  output logic                      eng_error
);

  localparam int unsigned QCntW = $clog2(QDEPTH) + 1;

  if (WATCHDOG_CYCLES < 1 || WATCHDOG_CYCLES > 65535) begin : g_bad_wdog
    $error("block_engine_sequencer: WATCHDOG_CYCLES must fit the 16-bit watchdog counter");
  end

  seq_state_e                state_q, state_d;
  logic [BSIZE-1:0]          operand_q, operand_d;
  logic                      eng_start_q, eng_start_d;
  logic [ProcCountWidth-1:0] processed_q, processed_d;
  logic [QCntW-1:0]          qcount;
  logic                      q_empty, q_full;
  logic                      res_push;
  logic                      wdog_expired;

`ifdef ENGINE_WATCHDOG_EN
  logic [WdogCountWidth-1:0] wdog_q, wdog_d;
  logic                      eng_error_q, eng_error_d;

  assign wdog_expired = (wdog_q == WdogCountWidth'(WATCHDOG_CYCLES - 1));
  assign eng_error    = eng_error_q;

  always_comb begin
    wdog_d      = wdog_q;
    eng_error_d = eng_error_q;
    if (state_q == StStart) begin
      wdog_d = '0;
    end else if (state_q == StWait) begin
      wdog_d = wdog_q + WdogCountWidth'(1);
      if (!eng_done && wdog_expired) begin
        eng_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_q      <= '0;
      eng_error_q <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      eng_error_q <= eng_error_d;
    end
  end
`else
  assign wdog_expired = 1'b0;
  assign eng_error    = 1'b0;
`endif

  // Full check at acceptance reserves the slot the in-flight result will use.
  assign block_in_hold    = (state_q != StIdle) || (qcount == QCntW'(QDEPTH));
  assign eng_block        = operand_q;
  assign eng_start        = eng_start_q;
  assign blocks_processed = processed_q;
  assign block_out_ready  = !q_empty;

  always_comb begin
    state_d     = state_q;
    operand_d   = operand_q;
    eng_start_d = 1'b0;
    processed_d = processed_q;
    res_push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (block_in_ready && !block_in_hold) begin
          operand_d   = block_in;
          eng_start_d = 1'b1;
          state_d     = StStart;
        end
      end
      StStart: state_d = StWait;
      StWait: begin
        if (eng_done) begin
          res_push    = 1'b1;
          processed_d = processed_q + ProcCountWidth'(1);
          state_d     = StIdle;
        end else if (wdog_expired) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      operand_q   <= '0;
      eng_start_q <= 1'b0;
      processed_q <= '0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      eng_start_q <= eng_start_d;
      processed_q <= processed_d;
    end
  end

  block_result_queue #(
    .Width (BSIZE),
    .Depth (QDEPTH)
  ) u_queue (
    .clock   (clock),
    .reset   (reset),
    .push_i  (res_push),
    .wdata_i (eng_result),
    .pop_i   (pull_block),
    .rdata_o (block_out),
    .count_o (qcount),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  assert property (@(posedge clock) disable iff (reset) res_push |-> !q_full)
    else $error("result pushed into a full queue");

endmodule

// File: tb/tb_block_engine_sequencer.sv
// Self-checking bench: directed table, hand-written corner sequences, randomized model check.
module tb_block_engine_sequencer;

  localparam int QD = 4;
  localparam int WD = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] block_in;
  logic         block_in_ready;
  logic         block_in_hold;
  logic [127:0] eng_block;
  logic         eng_start;
  logic [127:0] eng_result;
  logic         eng_done;
  logic [127:0] block_out;
  logic         block_out_ready;
  logic         pull_block;
  logic [15:0]  blocks_processed;
  logic         eng_error;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  block_engine_sequencer #(
    .BSIZE           (128),
    .QDEPTH          (QD),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .block_in         (block_in),
    .block_in_ready   (block_in_ready),
    .block_in_hold    (block_in_hold),
    .eng_block        (eng_block),
    .eng_start        (eng_start),
    .eng_result       (eng_result),
    .eng_done         (eng_done),
    .block_out        (block_out),
    .block_out_ready  (block_out_ready),
    .pull_block       (pull_block),
    .blocks_processed (blocks_processed),
    .eng_error        (eng_error)
  );

  typedef struct {
    bit          rdy;
    bit          done;
    bit          pull;
    bit          e_hold;
    bit          e_start;
    bit          e_ready;
    bit          e_bout;   // block_out expected to be ~OP (else 0)
    bit          e_opnd;   // eng_block expected to be OP (else 0)
    logic [15:0] e_proc;
  } vec_t;

  localparam logic [127:0] OP = 128'h0123456789abcdef0123456789abcdef;

  // Reference model state
  bit           m_busy;
  int           m_age;
  logic [127:0] m_op;
  logic [127:0] mq[$];
  logic [15:0]  m_cnt;
  bit           m_err;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    block_in = '0;
    block_in_ready = 1'b0;
    eng_result = '0;
    eng_done = 1'b0;
    pull_block = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [127:0] opv(input int i);
    return {4{32'h10203040 + 32'(i) * 32'h01010101}};
  endfunction

  function automatic logic [127:0] resv(input int i);
    return ~opv(i) ^ 128'(i + 7);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one block, wait for acceptance, answer with res lat cycles after the start pulse.
  task automatic feed(input logic [127:0] op, input logic [127:0] res, input int lat,
                      input bit pull_at_done);
    int n = 0;
    block_in = op;
    block_in_ready = 1'b1;
    while (block_in_hold && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      chk("feed_accept_timeout", 1'b0, 1'b1);
      block_in_ready = 1'b0;
      return;
    end
    tick();
    block_in_ready = 1'b0;
    chk("feed_start", eng_start, 1'b1);
    chk("feed_eng_block", eng_block, op);
    tick();
    repeat (lat - 1) tick();
    eng_result = res;
    eng_done = 1'b1;
    pull_block = pull_at_done;
    tick();
    eng_done = 1'b0;
    pull_block = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [127:0] exp);
    chk(name, block_out, exp);
    pull_block = 1'b1;
    tick();
    pull_block = 1'b0;
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_age = 0;
    m_op = '0;
    mq.delete();
    m_cnt = '0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit rdy, input logic [127:0] blk, input bit done,
                            input logic [127:0] res, input bit pull, input bit hold_now);
    if (pull && mq.size() != 0) void'(mq.pop_front());
    if (m_busy) begin
      if (m_age >= 1 && done) begin
        mq.push_back(res);
        m_cnt = m_cnt + 16'd1;
        m_busy = 1'b0;
      end
`ifdef ENGINE_WATCHDOG_EN
      else if (m_age == WD) begin
        m_err = 1'b1;
        m_busy = 1'b0;
      end
`endif
      else m_age++;
    end else if (rdy && !hold_now) begin
      m_busy = 1'b1;
      m_age = 0;
      m_op = blk;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not reach the end of the test");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int   starts;
    int   n;

    // Single block, with spurious done pulses in IDLE and START.
    tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0, 16'd0};
    tbl[1] = '{1, 1, 0, 1, 1, 0, 0, 1, 16'd0};
    tbl[2] = '{0, 0, 0, 1, 0, 0, 0, 1, 16'd0};
    tbl[3] = '{0, 0, 0, 1, 0, 0, 0, 1, 16'd0};
    tbl[4] = '{0, 0, 0, 1, 0, 0, 0, 1, 16'd0};
    tbl[5] = '{0, 0, 0, 1, 0, 0, 0, 1, 16'd0};
    tbl[6] = '{0, 1, 0, 1, 0, 0, 0, 1, 16'd0};
    tbl[7] = '{0, 1, 0, 0, 0, 1, 1, 1, 16'd1};
    tbl[8] = '{0, 0, 1, 0, 0, 1, 1, 1, 16'd1};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 16'd1};

    do_reset();
    chk("reset_hold", block_in_hold, 1'b0);
    chk("reset_error", eng_error, 1'b0);
    block_in = OP;
    eng_result = ~OP;
    for (int i = 0; i < 10; i++) begin
      block_in_ready = tbl[i].rdy;
      eng_done = tbl[i].done;
      pull_block = tbl[i].pull;
      #1;
      chk($sformatf("tbl%0d_hold", i), block_in_hold, tbl[i].e_hold);
      chk($sformatf("tbl%0d_start", i), eng_start, tbl[i].e_start);
      chk($sformatf("tbl%0d_ready", i), block_out_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_bout", i), block_out, tbl[i].e_bout ? ~OP : 128'd0);
      chk($sformatf("tbl%0d_eblk", i), eng_block, tbl[i].e_opnd ? OP : 128'd0);
      chk($sformatf("tbl%0d_proc", i), blocks_processed, tbl[i].e_proc);
      tick();
    end
    block_in_ready = 1'b0;
    eng_done = 1'b0;
    pull_block = 1'b0;

    // Queue fill: the fifth block must wait for a pop.
    do_reset();
    for (int i = 0; i < 4; i++) feed(opv(i), resv(i), 2, 1'b0);
    chk("fill_hold_full", block_in_hold, 1'b1);
    block_in = opv(4);
    block_in_ready = 1'b1;
    starts = 0;
    repeat (5) begin
      tick();
      if (eng_start) starts++;
    end
    chk("fill_no_accept", starts, 0);
    chk("fill_hold_still", block_in_hold, 1'b1);
    pop_expect("fill_head0", resv(0));
    chk("fill_hold_released", block_in_hold, 1'b0);
    feed(opv(4), resv(4), 3, 1'b0);
    for (int i = 1; i < 5; i++) pop_expect($sformatf("fill_order%0d", i), resv(i));
    chk("fill_empty", block_out_ready, 1'b0);
    chk("fill_count", blocks_processed, 16'd5);

    // Simultaneous push/pop at two entries, tail wrapping past the last slot.
    do_reset();
    for (int i = 0; i < 3; i++) feed(opv(10 + i), resv(10 + i), 1, 1'b0);
    pop_expect("wrap_pop0", resv(10));
    feed(opv(13), resv(13), 2, 1'b1);
    chk("wrap_head", block_out, resv(12));
    feed(opv(14), resv(14), 1, 1'b0);
    for (int i = 12; i < 15; i++) pop_expect($sformatf("wrap_order%0d", i), resv(i));
    chk("wrap_empty", block_out_ready, 1'b0);

    // Reset in WAIT with two results queued; a late done is ignored.
    do_reset();
    feed(opv(20), resv(20), 1, 1'b0);
    feed(opv(21), resv(21), 1, 1'b0);
    block_in = opv(22);
    block_in_ready = 1'b1;
    tick();
    block_in_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_hold", block_in_hold, 1'b0);
    chk("rst_start", eng_start, 1'b0);
    chk("rst_ready", block_out_ready, 1'b0);
    chk("rst_bout", block_out, 128'd0);
    chk("rst_eblk", eng_block, 128'd0);
    chk("rst_proc", blocks_processed, 16'd0);
    chk("rst_error", eng_error, 1'b0);
    reset = 1'b0;
    eng_result = resv(22);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("late_done_ready", block_out_ready, 1'b0);
    chk("late_done_proc", blocks_processed, 16'd0);
    chk("late_done_hold", block_in_hold, 1'b0);

`ifdef ENGINE_WATCHDOG_EN
    // No done: error after WD wait cycles, then normal operation resumes.
    do_reset();
    block_in = opv(30);
    block_in_ready = 1'b1;
    tick();
    block_in_ready = 1'b0;
    n = 0;
    while (!eng_error && n < 40) begin
      tick();
      n++;
    end
    chk("wd_cycles", n, 1 + WD);
    chk("wd_idle", block_in_hold, 1'b0);
    chk("wd_no_write", block_out_ready, 1'b0);
    feed(opv(31), resv(31), 4, 1'b0);
    chk("wd_recover_bout", block_out, resv(31));
    chk("wd_recover_proc", blocks_processed, 16'd1);
    chk("wd_sticky", eng_error, 1'b1);
`else
    n = 0;
`endif

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      bit           e_hold;
      logic [127:0] e_bout;
      block_in_ready = ($urandom_range(0, 2) != 0);
      eng_done = ($urandom_range(0, 3) == 0);
      pull_block = ($urandom_range(0, 2) == 0);
      block_in = rand128();
      eng_result = rand128();
      #1;
      e_hold = m_busy || (mq.size() == QD);
      e_bout = (mq.size() != 0) ? mq[0] : 128'd0;
      chk("rnd_hold", block_in_hold, e_hold);
      chk("rnd_start", eng_start, m_busy && m_age == 0);
      chk("rnd_ready", block_out_ready, mq.size() != 0);
      chk("rnd_bout", block_out, e_bout);
      chk("rnd_eblk", eng_block, m_op);
      chk("rnd_proc", blocks_processed, m_cnt);
      chk("rnd_error", eng_error, m_err);
      model_step(block_in_ready, block_in, eng_done, eng_result, pull_block, e_hold);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
